// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file read port.
// Contents:
//   clog2_min1  - ceil(log2(n)), never below 1, so index fields keep a real width.
//   *_DEF       - default geometry (registers, register width, beat width).
//   NUM_BEATS   - beats needed to stream one register.
//   BEAT_W      - width of the beat index.
//   ADDR_W      - width of a register address.
//   rd_state_e  - read-port FSM states.
package vrf_pkg;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_REG_DEF = 32;
    localparam int unsigned VLEN_DEF    = 128;
    localparam int unsigned ELEN_DEF    = 32;

    localparam int unsigned NUM_BEATS = VLEN_DEF / ELEN_DEF;
    localparam int unsigned BEAT_W    = clog2_min1(NUM_BEATS);
    localparam int unsigned ADDR_W    = clog2_min1(NUM_REG_DEF);

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_e;

endpackage

// File: rtl/vrf_read_select.sv
// Combinational source select for the read port snapshot.
// Picks one register out of the flattened register file. When a write to the
// same register happens in the same cycle, the write data is forwarded. An
// address with no backing register (possible only when NUM_REG is not a power
// of two) yields zero.
// Ports:
//   regs_flat  in   live register contents, register i at [i*VLEN +: VLEN]
//   rd_addr    in   register to read
//   wr_en      in   register-file write enable
//   wr_addr    in   register-file write address
//   wr_data    in   register-file write data
//   sel_data   out  value to capture into the snapshot
module vrf_read_select
    import vrf_pkg::*;
#(
    parameter int unsigned NUM_REG = NUM_REG_DEF,
    parameter int unsigned VLEN    = VLEN_DEF,
    localparam int unsigned AW     = clog2_min1(NUM_REG)
) (
    input  logic [NUM_REG*VLEN-1:0] regs_flat,
    input  logic [AW-1:0]           rd_addr,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [VLEN-1:0]         wr_data,
    output logic [VLEN-1:0]         sel_data
);

    logic in_range;

    always_comb begin
        sel_data = '0;
        in_range = 1'b0;
        // Decoded mux: an address matching no register leaves sel_data at zero.
        for (int i = 0; i < int'(NUM_REG); i++) begin
            if (rd_addr == AW'(i)) begin
                sel_data = regs_flat[i*VLEN +: VLEN];
                in_range = 1'b1;
            end
        end
        // Forward a same-cycle write so the reader sees the newest value.
        if (in_range && wr_en && (wr_addr == rd_addr)) begin
            sel_data = wr_data;
        end
    end

endmodule

// File: rtl/vrf_read_port.sv
// Read port of the vector register file.
// Accepts a request for one register, captures its VLEN bits (with same-cycle
// write forwarding) and streams them out as VLEN/ELEN beats over valid/ready.
// A new request can be taken on the last-beat cycle, so streams run
// back-to-back without an idle cycle.
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   rd_req_valid   in   read request valid
//   rd_req_ready   out  request can be accepted this cycle
//   rd_addr        in   register to read
//   regs_flat      in   live register contents, register i at [i*VLEN +: VLEN]
//   wr_en          in   register-file write enable (forwarding only)
//   wr_addr        in   register-file write address
//   wr_data        in   register-file write data
//   rd_data_valid  out  beat valid
//   rd_data_ready  in   consumer accepts beat
//   rd_data        out  current element beat
//   rd_data_idx    out  index of the current beat
//   rd_data_last   out  current beat is the final one
//   busy           out  a stream is in progress
module vrf_read_port
    import vrf_pkg::*;
#(
    parameter int unsigned NUM_REG = NUM_REG_DEF,
    parameter int unsigned VLEN    = VLEN_DEF,
    parameter int unsigned ELEN    = ELEN_DEF,
    localparam int unsigned AW     = clog2_min1(NUM_REG),
    localparam int unsigned NB     = VLEN / ELEN,
    localparam int unsigned BW     = clog2_min1(NB)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [AW-1:0]           rd_addr,
    input  logic [NUM_REG*VLEN-1:0] regs_flat,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [VLEN-1:0]         wr_data,
    output logic                    rd_data_valid,
    input  logic                    rd_data_ready,
    output logic [ELEN-1:0]         rd_data,
    output logic [BW-1:0]           rd_data_idx,
    output logic                    rd_data_last,
    output logic                    busy
);

    rd_state_e       state_q, state_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [VLEN-1:0] snap_q, snap_d;
    logic [VLEN-1:0] sel_data;
    logic            last_cnt;
    logic            accept;
    logic            beat_xfer;

    vrf_read_select #(
        .NUM_REG (NUM_REG),
        .VLEN    (VLEN)
    ) u_select (
        .regs_flat (regs_flat),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sel_data  (sel_data)
    );

    // With a single beat per vector the counter never moves and every beat is last.
    assign last_cnt      = (cnt_q == BW'(NB - 1));
    assign rd_data_valid = (state_q == STREAM);
    assign busy          = rd_data_valid;
    assign rd_data_last  = last_cnt && rd_data_valid;
    assign rd_data_idx   = cnt_q;
    // Ready on the last accepted beat lets the next stream start with no bubble.
    assign rd_req_ready  = (state_q == IDLE) || (rd_data_last && rd_data_ready);
    assign accept        = rd_req_valid && rd_req_ready;
    assign beat_xfer     = rd_data_valid && rd_data_ready;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (cnt_q == BW'(i)) begin
                rd_data = snap_q[i*ELEN +: ELEN];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    snap_d  = sel_data;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat_xfer) begin
                    if (!last_cnt) begin
                        cnt_d = cnt_q + BW'(1);
                    end else if (accept) begin
                        snap_d = sel_data;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: tb/tb_vrf_read_port.sv
// Scoreboard bench for vrf_read_port: directed requests push hand-computed beats
// into a queue; a negedge monitor pops and compares every accepted beat.
module tb_vrf_read_port;

    localparam int unsigned NUM_REG = 32;
    localparam int unsigned VLEN    = 128;
    localparam int unsigned ELEN    = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    rd_req_valid;
    logic                    rd_req_ready;
    logic [4:0]              rd_addr;
    logic [NUM_REG*VLEN-1:0] regs_flat;
    logic                    wr_en;
    logic [4:0]              wr_addr;
    logic [VLEN-1:0]         wr_data;
    logic                    rd_data_valid;
    logic                    rd_data_ready;
    logic [ELEN-1:0]         rd_data;
    logic [1:0]              rd_data_idx;
    logic                    rd_data_last;
    logic                    busy;

    logic [VLEN-1:0] regs [NUM_REG];
    beat_t           exp_q[$];
    int              tests  = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NUM_REG); i++) regs_flat[i*VLEN +: VLEN] = regs[i];
    end

    vrf_read_port #(
        .NUM_REG (NUM_REG),
        .VLEN    (VLEN),
        .ELEN    (ELEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr       (rd_addr),
        .regs_flat     (regs_flat),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_data       (rd_data),
        .rd_data_idx   (rd_data_idx),
        .rd_data_last  (rd_data_last),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats of one vector, low element first.
    task automatic push_vec(input logic [127:0] v);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({v[i*32 +: 32], 2'(i), (i == 3)});
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, 64'(busy), 64'd0);
        check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && rd_data_valid && rd_data_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h idx %0d, expected no beat",
                         rd_data, rd_data_idx);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat", 64'({rd_data, rd_data_idx, rd_data_last}), 64'(e));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        rd_req_valid  = 1'b0;
        rd_addr       = '0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        rd_data_ready = 1'b0;
        for (int i = 0; i < int'(NUM_REG); i++) regs[i] = {4{32'hF000_0000 | 32'(i)}};
        regs[2] = 128'h0000002D_0000002C_0000002B_0000002A;
        regs[3] = 128'h00000033_00000032_00000031_00000030;
        regs[4] = 128'h00000043_00000042_00000041_00000040;
        regs[5] = 128'h0000000D_0000000C_0000000B_0000000A;
        regs[6] = 128'h00000063_00000062_00000061_00000060;
        regs[7] = 128'h77777777_77777777_77777777_77777777;
        regs[9] = 128'h00000093_00000092_00000091_00000090;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(rd_data_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_data", 64'(rd_data), 64'd0);
        check("reset_idx", 64'(rd_data_idx), 64'd0);
        check("reset_last", 64'(rd_data_last), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(rd_req_ready), 64'd1);
        tick();

        // Basic stream of register 5
        rd_data_ready = 1'b1;
        rd_addr       = 5'd5;
        rd_req_valid  = 1'b1;
        push_vec(128'h0000000D_0000000C_0000000B_0000000A);
        @(negedge clk);
        check("accept_cycle_valid", 64'(rd_data_valid), 64'd0);
        tick();
        rd_req_valid = 1'b0;
        @(negedge clk);
        check("first_beat_latency", 64'(rd_data_valid), 64'd1);
        check("first_beat_idx", 64'(rd_data_idx), 64'd0);
        repeat (3) tick();
        @(negedge clk);
        check("last_beat_flag", 64'(rd_data_last), 64'd1);
        check("last_beat_ready", 64'(rd_req_ready), 64'd1);
        tick();
        wait_idle("basic");

        // Same-cycle write forwarding
        rd_addr      = 5'd7;
        rd_req_valid = 1'b1;
        wr_en        = 1'b1;
        wr_addr      = 5'd7;
        wr_data      = {4{32'h11111111}};
        push_vec({4{32'h11111111}});
        tick();
        regs[7]      = wr_data;
        wr_en        = 1'b0;
        rd_req_valid = 1'b0;
        wait_idle("forward");

        // Write to the streamed register mid-stream
        rd_addr      = 5'd2;
        rd_req_valid = 1'b1;
        push_vec(128'h0000002D_0000002C_0000002B_0000002A);
        tick();
        rd_req_valid = 1'b0;
        tick();
        wr_en   = 1'b1;
        wr_addr = 5'd2;
        wr_data = {4{32'hDEADBEEF}};
        regs[2] = {4{32'hDEADBEEF}};
        tick();
        wr_en = 1'b0;
        wait_idle("snapshot_hold");

        // Consumer stall at idx 1
        rd_addr      = 5'd4;
        rd_req_valid = 1'b1;
        push_vec(128'h00000043_00000042_00000041_00000040);
        tick();
        rd_req_valid = 1'b0;
        tick();
        rd_data_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_idx", 64'(rd_data_idx), 64'd1);
            check("stall_data", 64'(rd_data), 64'h41);
            tick();
        end
        rd_data_ready = 1'b1;
        wait_idle("stall");

        // Back-to-back: request for 9 held from idx 1 of register 3
        rd_addr      = 5'd3;
        rd_req_valid = 1'b1;
        push_vec(128'h00000033_00000032_00000031_00000030);
        tick();
        rd_req_valid = 1'b0;
        tick();
        rd_addr      = 5'd9;
        rd_req_valid = 1'b1;
        push_vec(128'h00000093_00000092_00000091_00000090);
        @(negedge clk);
        check("held_req_not_ready", 64'(rd_req_ready), 64'd0);
        repeat (2) tick();
        @(negedge clk);
        check("b2b_ready_on_last", 64'(rd_req_ready), 64'd1);
        tick();
        rd_req_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_bubble", 64'({rd_data_valid, rd_data_idx, rd_data}), {31'd0, 1'b1, 2'd0, 32'h90});
        wait_idle("b2b");

        // Reset mid-stream at idx 2
        rd_addr      = 5'd6;
        rd_req_valid = 1'b1;
        push_vec(128'h00000063_00000062_00000061_00000060);
        tick();
        rd_req_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("pre_reset_idx", 64'(rd_data_idx), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("abort_valid", 64'(rd_data_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_idx_last_data", 64'({rd_data_idx, rd_data_last, rd_data}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        rd_addr      = 5'd5;
        rd_req_valid = 1'b1;
        push_vec(128'h0000000D_0000000C_0000000B_0000000A);
        tick();
        rd_req_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idx", 64'(rd_data_idx), 64'd0);
        wait_idle("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
